// File: rtl/scope_pkg.sv
// Shared types and default geometry for the scope capture path.
package scope_pkg;

    localparam int SCOPE_DEPTH    = 640;
    localparam int SCOPE_ADDR_W   = 10;
    localparam int SCOPE_SAMPLE_W = 9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRETRIG   = 3'd1,
        ARMED     = 3'd2,
        POST      = 3'd3,
        WAIT_SWAP = 3'd4,
        HOLDOFF   = 3'd5
    } cap_state_t;

    typedef enum logic [1:0] {
        AUTO   = 2'd0,
        NORMAL = 2'd1,
        SINGLE = 2'd2
    } trig_mode_t;

    // Code 3 is reserved and behaves as normal mode.
    function automatic trig_mode_t decode_mode(input logic [1:0] code);
        case (code)
            2'd0:    return AUTO;
            2'd2:    return SINGLE;
            default: return NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/trig_detect.sv
// Slope/level trigger detector: keeps the previous accepted sample and flags
// a threshold crossing on the current one.
module trig_detect
    import scope_pkg::*;
#(
    parameter int SAMPLE_W = SCOPE_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                update,
    input  logic                arm,
    input  logic                slope,
    input  logic [SAMPLE_W-1:0] level,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                hit
);

    logic [SAMPLE_W-1:0] prev_reg;
    logic                prev_valid_reg;
    logic                rise;
    logic                fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
        end else if (clear) begin
            prev_valid_reg <= 1'b0;
        end else if (update) begin
            prev_reg       <= sample;
            prev_valid_reg <= 1'b1;
        end
    end

    assign rise = (prev_reg < level) && (sample >= level);
    assign fall = (prev_reg > level) && (sample <= level);
    assign hit  = arm && update && prev_valid_reg && (slope ? rise : fall);

endmodule

// File: rtl/capture_sequencer.sv
// Ping-pong ADC capture sequencer: pre-trigger fill, trigger, post fill, swap on
// frame boundary. Optional post-swap holdoff is enabled by SCOPE_HOLDOFF_EN.
module capture_sequencer
    import scope_pkg::*;
#(
    parameter int SAMPLE_W     = SCOPE_SAMPLE_W,
    parameter int DEPTH        = SCOPE_DEPTH,
    parameter int ADDR_W       = SCOPE_ADDR_W,
    parameter int PRE_DEPTH    = 160,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                run,
    input  logic [1:0]          mode,
    input  logic                slope,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic [15:0]         holdoff,
    input  logic                frame_done,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                wr_bank,
    output logic [ADDR_W-1:0]   disp_start,
    output logic                swap_pulse,
    output logic                auto_trig,
    output logic [2:0]          state
);

    localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
    localparam int CNT_MAX  = (AUTO_TIMEOUT > 65535) ? AUTO_TIMEOUT : 65535;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    cap_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    trig_mode_t          mode_reg, mode_next;
    logic                slope_reg, slope_next;
    logic [SAMPLE_W-1:0] level_reg, level_next;
    logic                auto_flag_reg, auto_flag_next;
    logic [ADDR_W-1:0]   trig_addr_reg, trig_addr_next;
    logic                single_lock_reg, single_lock_next;
    logic                wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [SAMPLE_W-1:0] wr_data_reg, wr_data_next;
    logic                wr_bank_reg, wr_bank_next;
    logic [ADDR_W-1:0]   disp_start_reg, disp_start_next;
    logic                swap_pulse_reg, swap_pulse_next;
    logic                auto_trig_reg, auto_trig_next;

    logic                capture;
    logic                prev_clear;
    logic                trig_hit;
    logic [ADDR_W-1:0]   disp_calc;

`ifdef SCOPE_HOLDOFF_EN
    logic [15:0]         holdoff_len_reg, holdoff_len_next;
`else
    logic                unused_holdoff;
    assign unused_holdoff = ^holdoff;
`endif

    // A sample is written in every filling state while run is held.
    assign capture = run && sample_valid &&
                     ((state_reg == PRETRIG) || (state_reg == ARMED) ||
                      (state_reg == POST)    || (state_reg == HOLDOFF));

    assign disp_calc = (trig_addr_reg >= ADDR_W'(PRE_DEPTH))
                     ? trig_addr_reg - ADDR_W'(PRE_DEPTH)
                     : trig_addr_reg + ADDR_W'(DEPTH - PRE_DEPTH);

    trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (prev_clear),
        .update  (capture),
        .arm     (state_reg == ARMED),
        .slope   (slope_reg),
        .level   (level_reg),
        .sample  (sample),
        .hit     (trig_hit)
    );

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        cnt_next         = cnt_reg;
        mode_next        = mode_reg;
        slope_next       = slope_reg;
        level_next       = level_reg;
        auto_flag_next   = auto_flag_reg;
        trig_addr_next   = trig_addr_reg;
        single_lock_next = single_lock_reg && run;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr_reg;
        wr_data_next     = wr_data_reg;
        wr_bank_next     = wr_bank_reg;
        disp_start_next  = disp_start_reg;
        swap_pulse_next  = 1'b0;
        auto_trig_next   = auto_trig_reg;
        prev_clear       = 1'b0;
`ifdef SCOPE_HOLDOFF_EN
        holdoff_len_next = holdoff_len_reg;
`endif

        if (!run) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!single_lock_reg) begin
                        mode_next  = decode_mode(mode);
                        slope_next = slope;
                        level_next = trig_level;
                        cnt_next   = '0;
                        prev_clear = 1'b1;
                        state_next = PRETRIG;
                    end
                end
                PRETRIG: begin
                    if (capture) begin
                        if (cnt_reg == CNT_W'(PRE_DEPTH - 1)) begin
                            cnt_next   = '0;
                            state_next = ARMED;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (capture) begin
                        if (trig_hit) begin
                            trig_addr_next = ptr_reg;
                            auto_flag_next = 1'b0;
                            cnt_next       = '0;
                            state_next     = POST;
                        end else if (mode_reg == AUTO) begin
                            if (cnt_reg == CNT_W'(AUTO_TIMEOUT - 1)) begin
                                trig_addr_next = ptr_reg;
                                auto_flag_next = 1'b1;
                                cnt_next       = '0;
                                state_next     = POST;
                            end else begin
                                cnt_next = cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                end
                POST: begin
                    if (capture) begin
                        if (cnt_reg == CNT_W'(POST_LEN - 1)) begin
                            cnt_next   = '0;
                            state_next = WAIT_SWAP;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (frame_done) begin
                        wr_bank_next    = !wr_bank_reg;
                        disp_start_next = disp_calc;
                        auto_trig_next  = auto_flag_reg;
                        swap_pulse_next = 1'b1;
                        if (mode_reg == SINGLE) begin
                            // Hold in IDLE until run is seen low.
                            single_lock_next = 1'b1;
                            state_next       = IDLE;
                        end else begin
                            mode_next  = decode_mode(mode);
                            slope_next = slope;
                            level_next = trig_level;
                            cnt_next   = '0;
                            prev_clear = 1'b1;
`ifdef SCOPE_HOLDOFF_EN
                            holdoff_len_next = holdoff;
                            state_next = (holdoff == 16'd0) ? PRETRIG : HOLDOFF;
`else
                            state_next = PRETRIG;
`endif
                        end
                    end
                end
`ifdef SCOPE_HOLDOFF_EN
                HOLDOFF: begin
                    if (capture) begin
                        if (cnt_reg == CNT_W'(holdoff_len_reg - 16'd1)) begin
                            cnt_next   = '0;
                            prev_clear = 1'b1;
                            state_next = PRETRIG;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end

        if (capture) begin
            wr_en_next   = 1'b1;
            wr_addr_next = ptr_reg;
            wr_data_next = sample;
            ptr_next     = (ptr_reg == ADDR_W'(DEPTH - 1)) ? '0 : ptr_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            cnt_reg         <= '0;
            mode_reg        <= NORMAL;
            slope_reg       <= 1'b1;
            level_reg       <= '0;
            auto_flag_reg   <= 1'b0;
            trig_addr_reg   <= '0;
            single_lock_reg <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            wr_bank_reg     <= 1'b0;
            disp_start_reg  <= '0;
            swap_pulse_reg  <= 1'b0;
            auto_trig_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            cnt_reg         <= cnt_next;
            mode_reg        <= mode_next;
            slope_reg       <= slope_next;
            level_reg       <= level_next;
            auto_flag_reg   <= auto_flag_next;
            trig_addr_reg   <= trig_addr_next;
            single_lock_reg <= single_lock_next;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
            wr_bank_reg     <= wr_bank_next;
            disp_start_reg  <= disp_start_next;
            swap_pulse_reg  <= swap_pulse_next;
            auto_trig_reg   <= auto_trig_next;
        end
    end

`ifdef SCOPE_HOLDOFF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdoff_len_reg <= '0;
        end else begin
            holdoff_len_reg <= holdoff_len_next;
        end
    end
`endif

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign wr_bank    = wr_bank_reg;
    assign disp_start = disp_start_reg;
    assign swap_pulse = swap_pulse_reg;
    assign auto_trig  = auto_trig_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: table of capture scenarios with a
// write scoreboard, plus hand-written run-drop, reset, single and holdoff cases.
module tb_capture_sequencer;

    localparam int DEPTH   = 640;
    localparam int PRE     = 160;
    localparam int POSTN   = 479;
    localparam int TIMEOUT = 4096;
    localparam int S_IDLE = 0, S_PRE = 1, S_ARMED = 2, S_POST = 3, S_WAIT = 4, S_HOLD = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [8:0]  sample = '0;
    logic        run = 1'b0;
    logic [1:0]  mode = 2'd1;
    logic        slope = 1'b1;
    logic [8:0]  trig_level = '0;
    logic [15:0] holdoff = '0;
    logic        frame_done = 1'b0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        wr_bank;
    logic [9:0]  disp_start;
    logic        swap_pulse;
    logic        auto_trig;
    logic [2:0]  state;

    always #5 clk = ~clk;

    capture_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .run          (run),
        .mode         (mode),
        .slope        (slope),
        .trig_level   (trig_level),
        .holdoff      (holdoff),
        .frame_done   (frame_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_bank      (wr_bank),
        .disp_start   (disp_start),
        .swap_pulse   (swap_pulse),
        .auto_trig    (auto_trig),
        .state        (state)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int mode;
        bit slope;
        int level;
        int kind;
        bit gaps;
        int exp_val;
        bit exp_auto;
        int exp_writes;
    } scen_t;

    wr_t   exp_q[$];
    scen_t tbl[7];
    int    shadow[2][DEPTH];
    int    n_checks = 0;
    int    n_fail = 0;
    int    n_writes = 0;

    // Reference model state
    int m_state, m_ptr, m_cnt, m_prev, m_mode, m_level, m_trig, m_disp, m_hold;
    bit m_prev_ok, m_slope, m_auto, m_bank, m_at, m_lock, m_swp, m_wr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_ptr = 0; m_cnt = 0; m_prev = 0; m_prev_ok = 0;
        m_bank = 0; m_disp = 0; m_at = 0; m_auto = 0; m_trig = 0; m_lock = 0;
        m_swp = 0; m_wr = 0; m_mode = 1; m_slope = 1; m_level = 0; m_hold = 0;
        exp_q.delete();
    endtask

    task automatic model_write();
        wr_t w;
        w.addr = m_ptr;
        w.data = int'(sample);
        exp_q.push_back(w);
        m_ptr = (m_ptr + 1) % DEPTH;
        m_wr = 1;
    endtask

    task automatic model_latch();
        m_mode = (mode == 2'd3) ? 1 : int'(mode);
        m_slope = slope;
        m_level = int'(trig_level);
        m_prev_ok = 0;
        m_cnt = 0;
    endtask

    task automatic model_step();
        int s;
        bit hit;
        s = int'(sample);
        m_swp = 0;
        m_wr = 0;
        if (!run) begin
            m_lock = 0;
            m_state = S_IDLE;
            return;
        end
        case (m_state)
            S_IDLE: if (!m_lock) begin model_latch(); m_state = S_PRE; end
            S_PRE: if (sample_valid) begin
                model_write(); m_prev = s; m_prev_ok = 1; m_cnt++;
                if (m_cnt == PRE) begin m_cnt = 0; m_state = S_ARMED; end
            end
            S_ARMED: if (sample_valid) begin
                hit = m_prev_ok && (m_slope ? (m_prev < m_level && s >= m_level)
                                            : (m_prev > m_level && s <= m_level));
                m_cnt++;
                if (hit || (m_mode == 0 && m_cnt == TIMEOUT)) begin
                    m_trig = m_ptr; m_auto = !hit; m_cnt = 0; m_state = S_POST;
                end
                model_write(); m_prev = s; m_prev_ok = 1;
            end
            S_POST: if (sample_valid) begin
                model_write(); m_cnt++;
                if (m_cnt == POSTN) begin m_cnt = 0; m_state = S_WAIT; end
            end
            S_WAIT: if (frame_done) begin
                m_bank = !m_bank;
                m_disp = (m_trig - PRE + DEPTH) % DEPTH;
                m_at = m_auto;
                m_swp = 1;
                if (m_mode == 2) begin
                    m_state = S_IDLE; m_lock = 1;
                end else begin
                    model_latch();
`ifdef SCOPE_HOLDOFF_EN
                    m_hold = int'(holdoff);
                    m_state = (holdoff == 16'd0) ? S_PRE : S_HOLD;
`else
                    m_state = S_PRE;
`endif
                end
            end
            S_HOLD: if (sample_valid) begin
                model_write(); m_cnt++;
                if (m_cnt == m_hold) begin m_cnt = 0; m_prev_ok = 0; m_state = S_PRE; end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        wr_t w;
        check("state", int'(state), m_state);
        check("wr_en", int'(wr_en), int'(m_wr));
        check("wr_bank", int'(wr_bank), int'(m_bank));
        check("disp_start", int'(disp_start), m_disp);
        check("auto_trig", int'(auto_trig), int'(m_at));
        check("swap_pulse", int'(swap_pulse), int'(m_swp));
        if (wr_en) begin
            shadow[wr_bank][wr_addr] = int'(wr_data);
            n_writes++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), w.addr);
                check("wr_data", int'(wr_data), w.data);
            end
        end
    endtask

    task automatic cycle(input bit v, input int s, input bit fd);
        sample_valid = v;
        sample = 9'(s);
        frame_done = fd;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic int gen(input int kind, input int idx);
        case (kind)
            0:       return idx % 512;
            1:       return (idx < 200) ? 50 : ((idx < 250) ? 200 : 90);
            default: return 300;
        endcase
    endfunction

    // Starts a fresh capture from IDLE and runs it through to the bank swap.
    task automatic run_scenario(input scen_t sc);
        int idx, waitc;
        bit v, fd, swapped;
        run = 1'b0;
        cycle(0, 0, 0);
        mode = 2'(sc.mode);
        slope = sc.slope;
        trig_level = 9'(sc.level);
        run = 1'b1;
        idx = 0; waitc = 0; swapped = 0; n_writes = 0;
        for (int c = 0; c < 20000 && !swapped; c++) begin
            v = (m_state == S_IDLE) ? 1'b0 : (sc.gaps ? ($urandom_range(3) != 0) : 1'b1);
            waitc = (m_state == S_WAIT) ? waitc + 1 : 0;
            // Includes a frame_done landing on the final POST write, which must be ignored.
            fd = (m_state == S_POST && v && m_cnt == POSTN - 1) || (waitc >= 4);
            cycle(v, gen(sc.kind, idx), fd);
            if (v) idx++;
            swapped = m_swp;
        end
        check("swap_reached", int'(swapped), 1);
        check("trig_sample", shadow[m_bank ^ 1'b1][(m_disp + PRE) % DEPTH], sc.exp_val);
        check("auto_flag", int'(auto_trig), int'(sc.exp_auto));
        check("capture_writes", n_writes, sc.exp_writes);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_until(input int st, input int limit, input string name);
        int idx;
        bit reached;
        idx = 0;
        reached = 0;
        for (int c = 0; c < limit && !reached; c++) begin
            cycle(1, gen(0, idx), 0);
            idx++;
            reached = (m_state == st);
        end
        check(name, int'(reached), 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit bank_b;
        int disp_b;
        tbl[0] = '{1, 1'b1, 256, 0, 1'b0, 256, 1'b0, 736};
        tbl[1] = '{1, 1'b0, 100, 1, 1'b1, 90,  1'b0, 730};
        tbl[2] = '{0, 1'b1, 256, 2, 1'b0, 300, 1'b1, 4735};
        tbl[3] = '{3, 1'b1, 10,  0, 1'b0, 10,  1'b0, 1002};
        tbl[4] = '{1, 1'b1, 511, 0, 1'b0, 511, 1'b0, 991};
        tbl[5] = '{1, 1'b0, 0,   0, 1'b1, 0,   1'b0, 992};
        tbl[6] = '{2, 1'b1, 256, 0, 1'b0, 256, 1'b0, 736};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
        cycle(0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            run_scenario(tbl[i]);
            $display("scenario %0d: mode=%0d slope=%0d level=%0d disp_start=%0d auto_trig=%0d writes=%0d",
                     i, tbl[i].mode, tbl[i].slope, tbl[i].level, disp_start, auto_trig, n_writes);
        end

        // Single mode: stays idle with run held high, re-arms only after run toggles.
        check("single_idle", int'(state), S_IDLE);
        n_writes = 0;
        for (int i = 0; i < 700; i++) cycle(1, i % 512, 0);
        check("single_no_writes", n_writes, 0);
        run = 1'b0;
        cycle(1, 0, 0);
        run = 1'b1;
        cycle(1, 0, 0);
        check("single_rearm", int'(state), S_PRE);
        $display("single: rearmed state=%0d", state);

        // Normal mode never auto-triggers on a flat input.
        run = 1'b0;
        cycle(0, 0, 0);
        mode = 2'd1; slope = 1'b1; trig_level = 9'd256; run = 1'b1;
        for (int i = 0; i < 5000; i++) cycle(1, 300, 0);
        check("normal_stays_armed", int'(state), S_ARMED);
        $display("normal flat: state=%0d after 5000 samples", state);

        // Dropping run during POST abandons the capture without a swap.
        run = 1'b0;
        cycle(0, 0, 0);
        mode = 2'd1; slope = 1'b1; trig_level = 9'd256; run = 1'b1;
        run_until(S_POST, 2000, "reach_post");
        for (int i = 0; i < 10; i++) cycle(1, i, 0);
        bank_b = m_bank;
        disp_b = m_disp;
        run = 1'b0;
        cycle(1, 7, 1);
        check("abort_idle", int'(state), S_IDLE);
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_bank", int'(wr_bank), int'(bank_b));
        check("abort_disp", int'(disp_start), disp_b);
        $display("run drop: state=%0d wr_bank=%0d disp_start=%0d", state, wr_bank, disp_start);

        // Asynchronous reset in the middle of ARMED.
        run = 1'b1;
        run_until(S_ARMED, 2000, "reach_armed");
        for (int i = 0; i < 20; i++) cycle(1, 100 + i, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_wr_bank", int'(wr_bank), 0);
        check("rst_disp", int'(disp_start), 0);
        check("rst_swap", int'(swap_pulse), 0);
        check("rst_auto", int'(auto_trig), 0);
        $display("async reset: state=%0d wr_bank=%0d wr_data=%0d", state, wr_bank, wr_data);
        model_reset();
        run = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(0, 0, 0);

`ifdef SCOPE_HOLDOFF_EN
        holdoff = 16'd20;
        run_scenario(tbl[0]);
        n = 0;
        while (state == 3'(S_HOLD) && n < 100) begin
            cycle(1, n, 0);
            n++;
        end
        check("holdoff_len", n, 20);
        check("holdoff_exit", int'(state), S_PRE);
        $display("holdoff=20: %0d samples in HOLDOFF", n);
        holdoff = 16'd0;
        run_scenario(tbl[0]);
        check("holdoff_zero", int'(state), S_PRE);
        $display("holdoff=0: state=%0d after swap", state);
`else
        holdoff = 16'd20;
        run_scenario(tbl[0]);
        check("no_holdoff", int'(state), S_PRE);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1, i, 0);
            if (state == 3'(S_HOLD)) n++;
        end
        check("holdoff_never", n, 0);
        $display("holdoff disabled: state=%0d after swap", state);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences acquisition of ADC samples into the two ping-pong sample banks that feed the VGA trace renderer.
- Fills a pre-trigger window, waits for a level/slope trigger (or auto timeout), and fills the post-trigger window.
- Then waits for the display frame boundary and swaps banks, handing the renderer the rotation offset of the trigger-aligned record.
- Sits between the ADC sample stream and the bank memories; the renderer reads the other bank.

Parameters:
- SAMPLE_W, 9, sample and trigger-level width.
- DEPTH, 640, samples per bank (one per display column).
- ADDR_W, 10, bank address width; DEPTH <= 2**ADDR_W.
- PRE_DEPTH, 160, samples kept before the trigger sample; 1 <= PRE_DEPTH <= DEPTH-2.
- AUTO_TIMEOUT, 4096, valid samples spent in ARMED before an auto trigger is forced.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe qualifying sample
- sample  in  SAMPLE_W  ADC code
- run  in  1  1 = acquire; 0 = return to IDLE
- mode  in  2  0 auto, 1 normal, 2 single, 3 treated as normal
- slope  in  1  1 rising, 0 falling
- trig_level  in  SAMPLE_W  trigger threshold
- holdoff  in  16  holdoff length in samples (used only with HOLDOFF_EN)
- frame_done  in  1  one-cycle pulse at the start of vertical blank
- wr_en  out  1  bank write enable
- wr_addr  out  ADDR_W  bank write address
- wr_data  out  SAMPLE_W  registered sample
- wr_bank  out  1  bank being written; renderer reads !wr_bank
- disp_start  out  ADDR_W  address of the oldest sample of the displayed record
- swap_pulse  out  1  one-cycle pulse on bank swap
- auto_trig  out  1  displayed record was auto-triggered
- state  out  3  current state encoding

Behaviour:
- Reset: state IDLE. wr_en, wr_addr, wr_data, wr_bank, disp_start, swap_pulse and auto_trig are all 0.
- States: IDLE, PRETRIG, ARMED, POST, WAIT_SWAP, HOLDOFF (HOLDOFF only with the macro).
- IDLE -> PRETRIG when run=1. On that transition, latch mode, slope and trig_level; clear the pre-trigger count and the previous-sample valid flag. wr_addr continues from its current value.
- Every sample_valid in PRETRIG, ARMED or POST:
  - next cycle wr_en=1, wr_data=sample, wr_addr=current pointer;
  - the pointer then increments, wrapping DEPTH-1 -> 0.
  - Latency is 1 cycle. wr_en is 0 in all other cycles.
- PRETRIG: count PRE_DEPTH valid samples, then go to ARMED. No trigger detection in PRETRIG; it updates prev only.
- ARMED: writes continue circularly.
  - Rising trigger: prev < level && cur >= level.
  - Falling trigger: prev > level && cur <= level.
  - prev must be valid.
  - On a trigger, cur is written, trig_addr is latched as its address, and the state goes to POST.
  - Auto mode: when the ARMED sample count reaches AUTO_TIMEOUT, that sample is the trigger and the capture's auto flag is set.
  - Normal and single modes wait indefinitely.
- POST: write DEPTH-PRE_DEPTH-1 further samples, then go to WAIT_SWAP. The bank then holds exactly DEPTH samples.
- WAIT_SWAP: samples are dropped (wr_en=0). On the first frame_done:
  - toggle wr_bank;
  - disp_start <= (trig_addr - PRE_DEPTH) mod DEPTH;
  - auto_trig <= capture auto flag;
  - swap_pulse=1 for one cycle.
  - Next state: IDLE if mode is single (run must drop and rise again to re-arm); otherwise PRETRIG with config re-latched.
  - frame_done is ignored in all other states. A frame_done coinciding with the final POST write is not counted.
- run=0 in any state: next state IDLE, wr_en 0. wr_bank, disp_start and auto_trig are unchanged, so a partial capture never reaches the display.
- Simultaneous sample_valid and a state change: the sample is processed by the current state's rules.
- mode/slope/level changes mid-capture take effect only at the next latch point.

Optional Feature:
- Macro: SCOPE_HOLDOFF_EN.
- Defined: after a swap in non-single mode, enter HOLDOFF. Count `holdoff` valid samples with writes active, then go to PRETRIG. holdoff=0 skips the state.
- Undefined: go straight to PRETRIG, `holdoff` is ignored, and the HOLDOFF encoding is never produced.

Decomposition:
- scope_pkg holds:
  - the state enum (cap_state_t, 3-bit);
  - the mode enum (trig_mode_t: AUTO, NORMAL, SINGLE);
  - constants SCOPE_DEPTH=640, SCOPE_ADDR_W=10, SCOPE_SAMPLE_W=9.
- One sub-module, trig_detect: registered prev sample plus valid flag, slope/level compare, one-cycle hit output.

Test Plan:
- Normal rising, level 256: ramp 0..511 repeating with sample_valid every cycle. Expect trigger at sample value 256 after PRETRIG. wr_en count per capture is 160 + (ARMED writes) + 1 + 479. After frame_done, disp_start = trig_addr-160 mod 640, wr_bank=1, swap_pulse high for one cycle.
- Falling, level 100: constant 50 then step to 200 then to 90. Trigger only on the 200->90 sample; the 50->200 step does not trigger.
- Auto mode, AUTO_TIMEOUT=4096: constant input. Trigger on the 4096th ARMED sample, auto_trig=1 after swap. Normal mode with the same stimulus stays in ARMED indefinitely.
- Single mode: one swap, then state IDLE. A further trigger produces no writes until run toggles 0->1.
- run dropped during POST: IDLE next cycle, wr_en 0, wr_bank and disp_start unchanged. reset_n asserted mid-ARMED clears all outputs asynchronously.
- SCOPE_HOLDOFF_EN, holdoff=20: after a swap exactly 20 valid samples pass in HOLDOFF before PRETRIG. holdoff=0 goes directly to PRETRIG.
